// File: rtl/mux_pipe_pkg.sv
// Shared types and defaults for the pipelined N-way selector.
// Holds the skid-buffer occupancy state encoding.
package mux_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;

endpackage

// File: rtl/mux_nx1_pipe_skid_buf_2.sv
// 2-entry valid/ready skid buffer: main register drives the output, skid catches one overflow item.
// Latency 1 cycle; in_rdy is registered and drops only when both entries are occupied.
// Backpressure: out_rdy low holds main stable; flush empties both entries and keeps data.
module skid_buf_2 import mux_pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  input  logic             flush
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_rdy_q;
  logic             accept, pop;
  logic             load_main_in, load_main_skid, load_skid;

  assign accept  = in_vld & in_rdy_q;
  assign pop     = (state_q != ST_EMPTY) & out_rdy;
  assign in_rdy  = in_rdy_q;
  assign out_vld = (state_q != ST_EMPTY);
  assign out_dat = main_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_rdy is low here, so only a pop can happen; skid drains into main
        if (pop) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      in_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)
        main_q <= in_dat;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_dat;
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-way WIDTH-bit selector feeding a 2-entry skid buffer; optional sticky bad-select flag (MUX_SEL_CHECK_EN).
// Latency 1 cycle from accept to OUT; throughput 1 item per cycle.
// Backpressure: OUT_READY low fills the skid entry, then IN_READY (registered) drops.
module mux_nx1_pipe import mux_pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SEL_W = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N*WIDTH-1:0] IN,
  input  logic [SEL_W-1:0]   SELECT,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [WIDTH-1:0]   OUT,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  input  logic               FLUSH,
  output logic               SEL_ERR
);

  logic [WIDTH-1:0] sel_dat;

  // Indices at or above N match nothing and leave the value at zero.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (SELECT == SEL_W'(k))
        sel_dat = IN[k*WIDTH +: WIDTH];
    end
  end

  skid_buf_2 #(.WIDTH(WIDTH)) u_skid (
    .clk     (CLK),
    .reset   (RESET),
    .in_dat  (sel_dat),
    .in_vld  (IN_VALID),
    .in_rdy  (IN_READY),
    .out_dat (OUT),
    .out_vld (OUT_VALID),
    .out_rdy (OUT_READY),
    .flush   (FLUSH)
  );

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q;
  logic sel_oob;

  assign sel_oob = IN_VALID && IN_READY && (int'(SELECT) >= N);

  always_ff @(posedge CLK) begin
    if (RESET)
      sel_err_q <= 1'b0;
    else if (sel_oob)
      sel_err_q <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      assert (!sel_oob) else $error("mux_nx1_pipe: select %0d out of range (N=%0d)", SELECT, N);
  end

  assign SEL_ERR = sel_err_q;
`else
  assign SEL_ERR = 1'b0;
`endif

endmodule
